// File: rtl/sample_packetizer.sv
// -----------------------------------------------------------------------------
// sample_packetizer
//
// Buffers the 16-bit word stream from the sampler serializer in a small FIFO
// and re-emits it as bounded packets on a valid/ready stream toward the USB
// bulk endpoint. The serializer cannot be stalled, so a write that finds the
// FIFO full is dropped and recorded (sticky overflow flag plus a saturating
// drop counter) instead of back-pressuring the source.
//
// Packets close either after pkt_words transfers or at the FIFO tail captured
// by a flush request. The newest word is held back while it is the only word
// in the FIFO and nothing can mark it, so the word that ends a packet can
// always carry out_last.
//
// Output handshake: out_valid/out_data/out_last are presented together; a
// word moves when out_valid && out_ready on a rising clk edge. Once out_valid
// is high, out_valid, out_data and out_last hold until that transfer; only
// rst or clear can withdraw them.
//
// Parameters:
//   depth_log      FIFO depth is 2**depth_log words
//   pkt_words      maximum packet length in words (2..65536)
//   timeout_cycles idle cycles before an automatic flush (timeout build only)
//
// Build option:
//   SAMPLE_PACKETIZER_TIMEOUT_EN  when defined, an idle timer raises an
//   internal flush after timeout_cycles idle cycles with data waiting and no
//   flush in progress. When undefined there is no timer and timeout_cycles is
//   unused.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   clear       synchronous flush of all state, same effect as rst
//   in_data     word from the serializer
//   in_valid    word strobe, no backpressure
//   out_data    head word (0 while the FIFO is empty)
//   out_valid   out_data is valid
//   out_last    current word ends a packet, qualified by out_valid
//   out_ready   consumer accepts the presented word
//   flush       one-cycle request to close the packet at the current tail
//   level       FIFO occupancy
//   overflow    sticky, at least one word was dropped
//   drop_count  number of dropped words, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module sample_packetizer #(
  parameter int depth_log      = 6,
  parameter int pkt_words      = 32,
  parameter int timeout_cycles = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [15:0]          in_data,
  input  logic                 in_valid,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [depth_log:0]   level,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int                 depth        = 1 << depth_log;
  localparam int                 lw           = depth_log + 1;
  localparam logic [lw-1:0]      level_full   = lw'(depth);
  localparam logic [lw-1:0]      level_one    = lw'(1);
  localparam logic [depth_log-1:0] ptr_one    = depth_log'(1);
  localparam logic [15:0]        pkt_last_idx = 16'(pkt_words - 1);

  // Storage and pointers
  logic [15:0]          mem [depth];
  logic [depth_log-1:0] wr_ptr;
  logic [depth_log-1:0] rd_ptr;
  logic [lw-1:0]        level_q;
  logic [lw-1:0]        level_d;

  // Packet framing state
  logic [15:0]          pkt_cnt;     // transfers so far in the current packet
  logic [lw-1:0]        flush_cnt;   // words left up to the flushed tail
  logic [lw-1:0]        flush_cnt_d;
  logic                 flush_pend;  // a flush arrived while one was in progress
  logic                 flush_pend_d;

  // Drop bookkeeping
  logic                 overflow_q;
  logic [15:0]          drop_cnt_q;

  // Per-cycle events
  logic                 soft_rst;
  logic                 full;
  logic                 wr_en;
  logic                 drop;
  logic                 xfer;
  logic                 flush_req;
  logic                 flush_load;

  assign soft_rst = rst | clear;

  // Full is judged on the registered level, so a write that coincides with a
  // transfer while full is still dropped.
  assign full  = (level_q == level_full);
  assign wr_en = in_valid && !full && !soft_rst;
  assign drop  = in_valid && full;
  assign xfer  = out_valid && out_ready;

  assign level_d = level_q + lw'(wr_en) - lw'(xfer);

  // A flush request only captures a tail when no flush is in progress.
  assign flush_load = flush_req && (flush_cnt == '0);

  // ---------------------------------------------------------------------------
  // Idle timer (optional)
  // ---------------------------------------------------------------------------
`ifdef SAMPLE_PACKETIZER_TIMEOUT_EN
  localparam int tw = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  logic [tw-1:0] idle_cnt;
  logic          idle_counting;
  logic          timeout_hit;

  // The timer only runs while words wait and no flush region is open; it
  // holds its value otherwise.
  assign idle_counting = (level_q != '0) && (flush_cnt == '0);
  assign timeout_hit   = idle_counting && (idle_cnt == tw'(timeout_cycles - 1));

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      idle_cnt <= '0;
    end else if (wr_en || flush_load || timeout_hit) begin
      idle_cnt <= '0;
    end else if (idle_counting) begin
      idle_cnt <= idle_cnt + tw'(1);
    end
  end

  // The timer behaves exactly like a pulse on the flush port.
  assign flush_req = flush || timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = (timeout_cycles == 0);
  assign flush_req      = flush;
`endif

  // ---------------------------------------------------------------------------
  // Flush tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_cnt_d  = flush_cnt;
    flush_pend_d = flush_pend;
    if (flush_cnt == '0) begin
      // Capture the tail as it stands now. A word leaving this cycle is no
      // longer ahead of the tail, so it is not counted. Loading 0 means there
      // was nothing to mark and the request has no effect.
      if (flush_req) begin
        flush_cnt_d = level_q - lw'(xfer);
      end
    end else if (xfer) begin
      if (flush_cnt == level_one) begin
        // Flushed region complete. A queued request (or one arriving right
        // now) re-captures the tail as it will be next cycle, including any
        // word written this cycle.
        flush_cnt_d  = (flush_pend || flush_req) ? level_d : '0;
        flush_pend_d = 1'b0;
      end else begin
        flush_cnt_d = flush_cnt - level_one;
        if (flush_req) begin
          flush_pend_d = 1'b1;
        end
      end
    end else if (flush_req) begin
      flush_pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      pkt_cnt    <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (xfer) begin
        rd_ptr  <= rd_ptr + ptr_one;
        // Any word that carried out_last closes the packet, whether it was
        // the length limit or a flush that ended it.
        pkt_cnt <= out_last ? 16'd0 : pkt_cnt + 16'd1;
      end
      level_q    <= level_d;
      flush_cnt  <= flush_cnt_d;
      flush_pend <= flush_pend_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

  // Storage has no reset; nothing reads an entry before it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Hold-back rule: a lone word is shown only when it is already known to be
  // the last of its packet (length limit reached) or lies inside a flushed
  // region. With two or more words the head can never be the final word.
  assign out_valid = (level_q != '0) &&
                     ((level_q > level_one) ||
                      (pkt_cnt == pkt_last_idx) ||
                      (flush_cnt != '0));

  assign out_last  = (pkt_cnt == pkt_last_idx) || (flush_cnt == level_one);

  assign out_data  = (level_q != '0) ? mem[rd_ptr] : 16'd0;

  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sample_packetizer.sv
// -----------------------------------------------------------------------------
// tb_sample_packetizer
//
// Self-checking bench for sample_packetizer. A behavioural model tracks the
// FIFO as a queue of words with absolute sequence numbers; a flush is modelled
// as a mark on a specific sequence number, and packet length as a position
// counter. A negedge compare process checks every output against the model
// each cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_sample_packetizer;

  localparam int depth_log      = 6;
  localparam int depth          = 1 << depth_log;
  localparam int pkt_words      = 32;
  localparam int timeout_cycles = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk;
  logic                rst;
  logic                clear;
  logic [15:0]         in_data;
  logic                in_valid;
  logic [15:0]         out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic                flush;
  logic [depth_log:0]  level;
  logic                overflow;
  logic [15:0]         drop_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sample_packetizer #(
    .depth_log      (depth_log),
    .pkt_words      (pkt_words),
    .timeout_cycles (timeout_cycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .flush      (flush),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];     // words in the FIFO, head first
  int unsigned head_idx;     // sequence number of exp_q[0]
  int unsigned wseq;         // sequence number of the next accepted word
  int          pkt_pos;      // words already sent in the current packet
  bit          mark_on;      // a flush mark is active
  int unsigned mark;         // sequence number of the word the flush ends on
  bit          pend;         // another flush waits for the current mark
  bit          m_ovf;
  int          m_drops;
  int          idle;         // idle cycles counted by the timeout rule

  function automatic bit m_valid();
    return (exp_q.size() != 0) &&
           ((exp_q.size() >= 2) || (pkt_pos == pkt_words - 1) || mark_on);
  endfunction

  function automatic bit m_last();
    return (pkt_pos == pkt_words - 1) || (mark_on && (mark == head_idx));
  endfunction

  always @(posedge clk) begin
    if (rst || clear) begin
      exp_q.delete();
      head_idx = 0;
      wseq     = 0;
      pkt_pos  = 0;
      mark_on  = 1'b0;
      mark     = 0;
      pend     = 1'b0;
      m_ovf    = 1'b0;
      m_drops  = 0;
      idle     = 0;
    end else begin
      bit          xfer;
      bit          was_last;
      bit          freq;
      bit          wr;
      bit          fire;
      bit          had_mark;
      bit          load;
      int unsigned head_before;
      int unsigned tail_before;
      int          size_before;
      size_before = exp_q.size();
      xfer        = m_valid() && out_ready;
      was_last    = m_last();
      head_before = head_idx;
      tail_before = wseq - 1;
      had_mark    = mark_on;
      fire        = 1'b0;
`ifdef SAMPLE_PACKETIZER_TIMEOUT_EN
      fire = (size_before != 0) && !had_mark && (idle == timeout_cycles - 1);
`endif
      freq = flush || fire;
      wr   = in_valid && (size_before < depth);
      load = freq && !had_mark;

      if (xfer) begin
        void'(exp_q.pop_front());
        head_idx++;
        pkt_pos = was_last ? 0 : pkt_pos + 1;
      end
      if (wr) begin
        exp_q.push_back(in_data);
        wseq++;
      end else if (in_valid) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end

      if (!had_mark) begin
        // Mark the newest word still waiting after this cycle's transfer.
        if (freq && (size_before - int'(xfer) > 0)) begin
          mark_on = 1'b1;
          mark    = tail_before;
        end
      end else if (xfer && (head_before == mark)) begin
        mark_on = 1'b0;
        if (pend || freq) begin
          if (exp_q.size() > 0) begin
            mark_on = 1'b1;
            mark    = wseq - 1;
          end
          pend = 1'b0;
        end
      end else if (freq) begin
        pend = 1'b1;
      end

`ifdef SAMPLE_PACKETIZER_TIMEOUT_EN
      if (wr || load || fire) idle = 0;
      else if ((size_before != 0) && !had_mark) idle++;
`else
      if (load) idle = 0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and transfer log (negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  logic [15:0] log_d[$];
  bit          log_l[$];

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("level", 32'(level), exp_q.size());
      check("out_valid", 32'(out_valid), 32'(m_valid()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), m_drops);
      if (m_valid()) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        check("out_last", 32'(out_last), 32'(m_last()));
      end else if (exp_q.size() == 0) begin
        check("out_data_empty", 32'(out_data), 0);
      end
      if (out_valid && out_ready && !clear) begin
        log_d.push_back(out_data);
        log_l.push_back(out_last);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit iv, input logic [15:0] d, input bit fl, input bit rdy);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    repeat (n) cycle(1'b0, 16'd0, 1'b0, rdy);
  endtask

  // clear together with a write and a flush: clear must win.
  task automatic pulse_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int pct_tab[4] = '{0, 40, 80, 100};
  int rdy_pct;
  int n_last;

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Two full-length packets, streaming.
    clear_log();
    for (int i = 0; i < 64; i++) cycle(1'b1, 16'(i), 1'b0, 1'b1);
    idle_cycles(10, 1'b1);
    check("s1_count", log_d.size(), 64);
    n_last = 0;
    for (int i = 0; i < log_d.size(); i++) begin
      check("s1_data", 32'(log_d[i]), i);
      if (log_l[i]) n_last++;
    end
    check("s1_last_count", n_last, 2);
    if (log_d.size() == 64) begin
      check("s1_last31", 32'(log_l[31]), 1);
      check("s1_last63", 32'(log_l[63]), 1);
    end
    check("s1_level", 32'(level), 0);

    // Hold-back of a lone word, released by flush.
    clear_log();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(100 + i), 1'b0, 1'b1);
    idle_cycles(5, 1'b1);
    check("s2_count", log_d.size(), 4);
    n_last = 0;
    for (int i = 0; i < log_d.size(); i++) if (log_l[i]) n_last++;
    check("s2_no_last", n_last, 0);
    check("s2_held_valid", 32'(out_valid), 0);
    check("s2_held_level", 32'(level), 1);
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    check("s2_flush_valid", 32'(out_valid), 1);
    check("s2_flush_last", 32'(out_last), 1);
    check("s2_flush_data", 32'(out_data), 104);
    idle_cycles(3, 1'b1);
    check("s2_level", 32'(level), 0);

    // Overflow while stalled, then intact drain.
    pulse_clear();
    check("s3_clear_level", 32'(level), 0);
    clear_log();
    for (int i = 0; i < 70; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    check("s3_level", 32'(level), 64);
    check("s3_overflow", 32'(overflow), 1);
    check("s3_drops", 32'(drop_count), 6);
    check("s3_valid", 32'(out_valid), 1);
    check("s3_head", 32'(out_data), 0);
    idle_cycles(80, 1'b1);
    check("s3_count", log_d.size(), 64);
    n_last = 0;
    for (int i = 0; i < log_d.size(); i++) begin
      check("s3_data", 32'(log_d[i]), i);
      if (log_l[i]) n_last++;
    end
    check("s3_last_count", n_last, 2);

    // Output stability under flush and write while stalled.
    pulse_clear();
    clear_log();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(200 + i), 1'b0, 1'b0);
    check("s4_valid", 32'(out_valid), 1);
    check("s4_data", 32'(out_data), 200);
    check("s4_last", 32'(out_last), 0);
    cycle(1'b1, 16'd203, 1'b1, 1'b0);
    check("s4_hold_valid", 32'(out_valid), 1);
    check("s4_hold_data", 32'(out_data), 200);
    check("s4_hold_last", 32'(out_last), 0);
    check("s4_hold_level", 32'(level), 4);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    check("s4_hold2_data", 32'(out_data), 200);
    check("s4_hold2_last", 32'(out_last), 0);
    idle_cycles(6, 1'b1);
    check("s4_count", log_d.size(), 3);
    if (log_d.size() == 3) check("s4_last_on_202", 32'(log_l[2]), 1);
    check("s4_tail_held", 32'(out_valid), 0);
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    idle_cycles(3, 1'b1);
    check("s4_level", 32'(level), 0);

    // Flush during a flush: marks the 3rd and then the 5th word.
    pulse_clear();
    clear_log();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(300 + i), 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b1, 16'd303, 1'b1, 1'b0);
    cycle(1'b1, 16'd304, 1'b0, 1'b0);
    idle_cycles(8, 1'b1);
    check("s5_count", log_d.size(), 5);
    for (int i = 0; i < log_d.size(); i++) begin
      check("s5_data", 32'(log_d[i]), 300 + i);
      check("s5_last", 32'(log_l[i]), 32'((i == 2) || (i == 4)));
    end
    check("s5_level", 32'(level), 0);

    // Lone word with no flush: timer build releases it, default build holds it.
    pulse_clear();
    cycle(1'b1, 16'd500, 1'b0, 1'b1);
`ifdef SAMPLE_PACKETIZER_TIMEOUT_EN
    for (int k = 1; k <= 11; k++) begin
      check("s6_valid", 32'(out_valid), 32'(k == 11));
      if (k == 11) begin
        check("s6_last", 32'(out_last), 1);
        check("s6_data", 32'(out_data), 500);
      end else begin
        cycle(1'b0, 16'd0, 1'b0, 1'b1);
      end
    end
    idle_cycles(3, 1'b1);
`else
    for (int k = 0; k < 30; k++) begin
      check("s6_held_valid", 32'(out_valid), 0);
      cycle(1'b0, 16'd0, 1'b0, 1'b1);
    end
    check("s6_held_level", 32'(level), 1);
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    idle_cycles(3, 1'b1);
`endif
    check("s6_level", 32'(level), 0);

    // Randomized traffic with varying backpressure.
    rdy_pct = 100;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rdy_pct = pct_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 1499) == 0) begin
        pulse_clear();
      end else begin
        cycle($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 29) == 0,
              $urandom_range(0, 99) < rdy_pct);
      end
    end
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    idle_cycles(100, 1'b1);
    check("final_level", 32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
